// File: rtl/dma_rd_line_fifo.sv
// dma_rd_line_fifo
//   Buffers cache lines popped from the host DMA read FIFO (first-word-fall-
//   through) and presents them to the memory controller through valid/ready.
//   Counts delivered lines against a transfer size latched on start and flags
//   completion. The DMA pop never depends on i_line_ready, so a busy consumer
//   only stalls the DMA once the buffer is full.
//
// Optional feature macro: DMA_RD_FIFO_STALL_CNT_EN
//   When defined, adds o_stall_cycles, a saturating count of ACTIVE cycles
//   with o_line_valid=1 and i_line_ready=0.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start, i_size        transfer start pulse and size in lines
//   i_dma_empty            DMA read FIFO empty
//   i_dma_rd_data          DMA head line
//   o_dma_rd_en            pop DMA head this cycle
//   o_line_data            buffered head line
//   o_line_valid           o_line_data valid
//   i_line_ready           consumer accepts head this cycle
//   o_level                buffer occupancy
//   o_count                lines delivered this transfer
//   o_busy, o_done         transfer in progress / transfer complete
//   o_stall_cycles         (optional) output backpressure cycle count
module dma_rd_line_fifo #(
    parameter  int unsigned DATA_WIDTH = 512,
    parameter  int unsigned DEPTH      = 8,
    parameter  int unsigned SIZE_WIDTH = 43,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SIZE_WIDTH-1:0] i_size,
    input  logic                  i_dma_empty,
    input  logic [DATA_WIDTH-1:0] i_dma_rd_data,
    output logic                  o_dma_rd_en,
    output logic [DATA_WIDTH-1:0] o_line_data,
    output logic                  o_line_valid,
    input  logic                  i_line_ready,
    output logic [LVL_W-1:0]      o_level,
    output logic [SIZE_WIDTH-1:0] o_count,
    output logic                  o_busy,
    output logic                  o_done
`ifdef DMA_RD_FIFO_STALL_CNT_EN
    ,
    output logic [31:0]           o_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_rd_cnt;
    logic [SIZE_WIDTH-1:0] r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_valid;

    always_comb begin
        w_valid  = (r_level != '0);
        // Full blocks a push even if the head pops this cycle: keeps
        // i_line_ready out of the o_dma_rd_en path.
        w_push   = (r_state == S_ACTIVE) && !i_dma_empty &&
                   (r_level < LVL_W'(DEPTH)) && (r_rd_cnt < r_size);
        w_pop    = w_valid && i_line_ready;
        w_accept = i_start && (r_state != S_ACTIVE);
        w_last   = w_pop && ((r_count + SIZE_WIDTH'(1)) == r_size);
    end

    // Storage is not reset; o_line_data is masked while the buffer is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dma_rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_size   <= '0;
            r_rd_cnt <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_size   <= i_size;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rd_cnt <= '0;
            r_count  <= '0;
            r_state  <= (i_size == '0) ? S_DONE : S_ACTIVE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_rd_cnt <= r_rd_cnt + SIZE_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count  <= r_count + SIZE_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            if ((r_state == S_ACTIVE) && w_last) begin
                r_state <= S_DONE;
            end
        end
    end

    assign o_dma_rd_en  = w_push;
    assign o_line_valid = w_valid;
    assign o_line_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level      = r_level;
    assign o_count      = r_count;
    assign o_busy       = (r_state == S_ACTIVE);
    assign o_done       = (r_state == S_DONE);

`ifdef DMA_RD_FIFO_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_accept) begin
            r_stall_cycles <= '0;
        end else if ((r_state == S_ACTIVE) && w_valid && !i_line_ready &&
                     (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
